store_unit: RTL and testbench

- Store-side counterpart of the load extension path. Accepts one committed store (SB/SH/SW) with address and 32-bit register data.
- Serialises the store onto the byte-wide memory bus, least-significant byte first, one byte per enabled cycle.
- Signals completion to the commit/LSB logic.
- Sits between the load/store buffer and the memory/IO arbiter.

---
 rtl/store_unit.sv | 106 ++++++++++
 tb/tb_store_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// store_unit: serialises a committed SB/SH/SW onto the byte-wide memory bus.
// Ports: clk_in, rst_in, rdy_in | req_* request in | mem_a/mem_dout/mem_wr bus | done, busy status.
module store_unit #(
  parameter int          ADDR_W     = 32,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_order,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic              io_buffer_full,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              done,
  output logic              busy
);

  localparam logic [5:0] OP_SB = 6'd18;
  localparam logic [5:0] OP_SH = 6'd19;
  localparam logic [5:0] OP_SW = 6'd20;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [31:0]         wdata;
  logic [2:0]          cnt;
  logic [1:0]          idx;
  logic                stall;
  logic                last;

  // Bus address/data are pure functions of the latched store, so they
  // stay put across stalls and keep the final byte visible in IDLE.
  always_comb begin
    mem_a = base + ADDR_W'(idx);
    unique case (idx)
      2'd0:    mem_dout = wdata[7:0];
      2'd1:    mem_dout = wdata[15:8];
      2'd2:    mem_dout = wdata[23:16];
      default: mem_dout = wdata[31:24];
    endcase
  end

  assign stall     = io_buffer_full & (mem_a[17:16] == IO_BASE_HI);
  assign mem_wr    = (state == WRITE) & rdy_in & ~stall;
  assign last      = ({1'b0, idx} == (cnt - 3'd1));
  assign req_ready = (state == IDLE);
  assign busy      = (state == WRITE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      base  <= '0;
      wdata <= '0;
      cnt   <= 3'd1;
      idx   <= 2'd0;
      done  <= 1'b0;
    end else begin
      // done is a single-cycle pulse even if rdy_in drops right after.
      done <= 1'b0;
      if (rdy_in) begin
        unique case (state)
          IDLE: begin
            if (req_valid) begin
              unique case (req_order)
                OP_SB, OP_SH, OP_SW: begin
                  base  <= req_addr;
                  wdata <= req_data;
                  idx   <= 2'd0;
                  state <= WRITE;
                  unique case (req_order)
                    OP_SB:   cnt <= 3'd1;
                    OP_SH:   cnt <= 3'd2;
                    default: cnt <= 3'd4;
                  endcase
                end
                // Unknown opcode: swallow it and report completion.
                default: done <= 1'b1;
              endcase
            end
          end
          WRITE: begin
            if (mem_wr) begin
              if (last) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                idx <= idx + 2'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed stimulus with a scoreboard queue of expected
// bus writes and done pulses, checked by an independent monitor.
module tb_store_unit;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_order;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        io_buffer_full;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_done;
    logic [31:0] a;
    logic [7:0]  d;
  } ev_t;

  ev_t exp_q[$];

  store_unit #(.ADDR_W(32), .IO_BASE_HI(2'b11)) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_order(req_order),
    .req_addr(req_addr),
    .req_data(req_data),
    .io_buffer_full(io_buffer_full),
    .mem_a(mem_a),
    .mem_dout(mem_dout),
    .mem_wr(mem_wr),
    .done(done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [7:0] d);
    ev_t e;
    e.is_done = 1'b0;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_d();
    ev_t e;
    e.is_done = 1'b1;
    e.a = '0;
    e.d = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse and every bus write must match the queue head.
  always @(negedge clk) begin
    if (!rst_in) begin
      if (done) begin
        checks++;
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          failures++;
          $display("FAIL mon_done: unexpected done pulse at %0t", $time);
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (mem_wr) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          failures++;
          $display("FAIL mon_write: unexpected write a=%h d=%h", mem_a, mem_dout);
        end else if (mem_a !== exp_q[0].a || mem_dout !== exp_q[0].d) begin
          failures++;
          $display("FAIL mon_write: got a=%h d=%h expected a=%h d=%h",
                   mem_a, mem_dout, exp_q[0].a, exp_q[0].d);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present one request for exactly one edge; called just after a posedge.
  task automatic issue(input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] d);
    req_order = o;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    @(posedge clk) #1;
    req_valid = 1'b0;
  endtask

  // Wait until WRITE ends; that cycle must carry the done pulse.
  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin
        chk({name, "_done"}, {31'b0, done}, 32'd1);
        @(posedge clk) #1;
        return;
      end
      chk({name, "_ready_low"}, {31'b0, req_ready}, 32'd0);
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
    @(posedge clk) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    req_valid = 1'b0;
    req_order = 6'd0;
    req_addr = 32'd0;
    req_data = 32'd0;
    io_buffer_full = 1'b0;
    #2;
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk) #1;
    rst_in = 1'b0;
    @(posedge clk) #1;

    // SW aligned, no stalls
    exp_w(32'h1000, 8'hEF);
    exp_w(32'h1001, 8'hBE);
    exp_w(32'h1002, 8'hAD);
    exp_w(32'h1003, 8'hDE);
    exp_d();
    issue(6'd20, 32'h0000_1000, 32'hDEAD_BEEF);
    wait_idle("sw", 10);
    chk("idle_hold_a", mem_a, 32'h1003);
    chk("idle_wr_low", {31'b0, mem_wr}, 32'd0);

    // SH misaligned across a 4K boundary
    exp_w(32'h0FFF, 8'h78);
    exp_w(32'h1000, 8'h56);
    exp_d();
    issue(6'd19, 32'h0000_0FFF, 32'h1234_5678);
    wait_idle("sh", 10);

    // SB at the top of the address space
    exp_w(32'hFFFF_FFFF, 8'hAA);
    exp_d();
    issue(6'd18, 32'hFFFF_FFFF, 32'h0000_00AA);
    wait_idle("sb_top", 10);

    // SB to IO region with the IO buffer full for 3 cycles
    exp_w(32'h0003_0000, 8'h5A);
    exp_d();
    io_buffer_full = 1'b1;
    issue(6'd18, 32'h0003_0000, 32'hFFFF_FF5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("io_stall_wr", {31'b0, mem_wr}, 32'd0);
      chk("io_stall_a", mem_a, 32'h0003_0000);
      chk("io_stall_d", {24'b0, mem_dout}, 32'h5A);
      @(posedge clk) #1;
    end
    io_buffer_full = 1'b0;
    wait_idle("io_sb", 10);

    // Same stall pattern on a non-IO address: writes straight through
    exp_w(32'h0002_0000, 8'h3C);
    exp_d();
    io_buffer_full = 1'b1;
    issue(6'd18, 32'h0002_0000, 32'h0000_003C);
    @(negedge clk);
    chk("nonio_wr", {31'b0, mem_wr}, 32'd1);
    @(posedge clk) #1;
    io_buffer_full = 1'b0;
    chk("nonio_done", {31'b0, done}, 32'd1);
    @(posedge clk) #1;

    // SW with rdy_in low for 2 cycles after the second byte
    exp_w(32'h2000, 8'h44);
    exp_w(32'h2001, 8'h33);
    exp_w(32'h2002, 8'h22);
    exp_w(32'h2003, 8'h11);
    exp_d();
    issue(6'd20, 32'h0000_2000, 32'h1122_3344);
    @(posedge clk) #1;
    @(posedge clk) #1;
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rdy_low_wr", {31'b0, mem_wr}, 32'd0);
      chk("rdy_low_a", mem_a, 32'h2002);
      chk("rdy_low_d", {24'b0, mem_dout}, 32'h22);
      @(posedge clk) #1;
    end
    rdy_in = 1'b1;
    wait_idle("rdy", 10);

    // Back-to-back: SB then SW with req_valid held high
    exp_w(32'h3000, 8'h55);
    exp_d();
    exp_w(32'h4000, 8'h0D);
    exp_w(32'h4001, 8'hF0);
    exp_w(32'h4002, 8'hFE);
    exp_w(32'h4003, 8'hCA);
    exp_d();
    req_order = 6'd18;
    req_addr  = 32'h0000_3000;
    req_data  = 32'h0000_0055;
    req_valid = 1'b1;
    @(posedge clk) #1;
    req_order = 6'd20;
    req_addr  = 32'h0000_4000;
    req_data  = 32'hCAFE_F00D;
    @(posedge clk) #1;
    @(negedge clk);
    chk("b2b_done", {31'b0, done}, 32'd1);
    chk("b2b_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk) #1;
    req_valid = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_idle("b2b", 10);

    // Asynchronous reset mid-SW while the third byte is on the bus
    exp_w(32'h5000, 8'hD4);
    exp_w(32'h5001, 8'hC3);
    issue(6'd20, 32'h0000_5000, 32'hA1B2_C3D4);
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("mid_wr_before", {31'b0, mem_wr}, 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("mid_rst_wr", {31'b0, mem_wr}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_a", mem_a, 32'd0);
    @(posedge clk) #2;
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", {31'b0, done}, 32'd0);
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    end
    @(posedge clk) #1;

    // Unknown order code: no write, one done pulse
    exp_d();
    issue(6'd15, 32'h0000_6000, 32'h0000_0077);
    wait_idle("bad_op", 10);
    repeat (3) @(posedge clk);
    #1;

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
